clock_alarm_ctrl: RTL and testbench
===================================

// Module: clock_alarm_ctrl
// PURPOSE
//  Downstream consumer of the HH:MM:SS BCD time-of-day counter. Holds a programmable alarm
//  time (HH:MM), detects the HH:MM:00 match, and sequences ring / snooze / dismiss
//  with a pulsed buzzer output. Sits between the time-keeping core and the buzzer/LED pins.
// PARAMETERS
//  RING_SEC    60   ticks a RING lasts before auto-return to IDLE
//  SNOOZE_SEC  300  ticks spent in SNOOZE before re-entering RING
//  MAX_SNOOZE  3    snoozes allowed per alarm event; further snooze pulses ignored
//  CNT_W       10   width of ring/snooze tick counter (must hold max(RING_SEC,SNOOZE_SEC))
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active high
//  tick_1hz     in   1  one-cycle pulse; time inputs update on the edge it is high
//  hour_tens/hour_ones/min_tens/min_ones/sec_tens/sec_ones  in  4 each  current time, BCD
//  armed        in   1  level; alarm enabled
//  alm_inc_hour in   1  one-cycle pulse; alarm hour +1
//  alm_inc_min  in   1  one-cycle pulse; alarm minute +1
//  snooze       in   1  one-cycle pulse
//  dismiss      in   1  one-cycle pulse
//  alm_hour_tens/alm_hour_ones/alm_min_tens/alm_min_ones  out  4 each  alarm time, BCD
//  state        out  2  00 IDLE, 01 RING, 10 SNOOZE
//  ringing      out  1  registered; 1 iff state==RING
//  buzzer       out  1  registered; pulsed tone enable
//  snooze_left  out  2  MAX_SNOOZE minus snoozes used this event
//  chime        out  1  hourly chime pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset: alarm 00:00, state IDLE, ringing/buzzer/chime 0, counters 0, snooze_left=MAX_SNOOZE.
//  tick_d = tick_1hz delayed 1 cycle; time inputs sampled only when tick_d=1 (post-update).
//  match = armed & tick_d & HH:MM==alarm & sec==00; uses pre-increment alarm value.
//  IDLE->RING on match; ringing=1 and buzzer=1 on next edge; tick counter cleared.
//  RING: buzzer toggles on each tick_d; counter +1 per tick_d; at RING_SEC -> IDLE.
//  RING & snooze & snooze_left>0 -> SNOOZE, snooze_left-1, buzzer 0, counter cleared.
//  RING & snooze & snooze_left==0 -> ignored, stays RING.
//  SNOOZE: counter +1 per tick_d; at SNOOZE_SEC -> RING, counter cleared, buzzer=1.
//  dismiss in RING/SNOOZE -> IDLE, snooze_left=MAX_SNOOZE. Ignored in IDLE.
//  Priority, same cycle: rst > armed=0 (forces IDLE, clears all) > dismiss > snooze > timeout.
//  Match while RING/SNOOZE ignored (no re-trigger). Auto-timeout to IDLE reloads snooze_left.
//  Alarm edit allowed in any state: minute 59->00 with no carry into hour; hour 23->00,
//  tens/ones BCD-correct (09->10, 19->20). Both inc pulses same cycle: both applied.
//  Time inputs outside BCD range: never match (compare is exact), no error flag.
//  Reset mid-RING: outputs return to reset values on that edge, alarm time cleared.
// CONFIGURATION
//  CLOCK_ALARM_CHIME_EN defined: in IDLE with armed=1, tick_d & min==00 & sec==00 -> chime=1
//   for exactly one cycle; suppressed if the same tick is an alarm match.
//  Not defined: chime tied 0; no chime logic synthesised; port kept.
// STRUCTURE
//  clock_alarm_pkg: state enum (IDLE/RING/SNOOZE), BCD limit constants (9, 5, 2, 3).
//  Sub-module bcd_wrap_inc: 2-digit BCD +1 with programmable wrap (23 or 59), used twice.
// TESTING
//  Reset -> alarm 00:00, state 00, ringing/buzzer 0, snooze_left 3.
//  Alarm 07:30, armed, time steps 07:29:59->07:30:00 -> ringing=1 one edge after tick_d.
//  RING, no input for 60 ticks -> IDLE; buzzer toggled each tick, starting at 1.
//  Three snooze/re-ring cycles (300 ticks each) -> snooze_left 0; 4th snooze stays RING.
//  snooze and dismiss same cycle in RING -> IDLE, snooze_left 3.
//  alm_inc_hour at 23 -> 00; alm_inc_min at 59 -> 00, hour unchanged; 09->10 hour.
//  armed dropped mid-SNOOZE -> IDLE next edge; chime pulses at xx:00:00 only with macro set.

Source files
------------

// File: rtl/clock_alarm_pkg.sv
// Shared types and BCD limits for the alarm controller slice.
package clock_alarm_pkg;

  // Alarm sequencing states; encodings are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10
  } alarm_state_t;

  // BCD digit limits used for wrap detection.
  localparam logic [3:0] BCD_ONES_MAX  = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX  = 4'd5;
  localparam logic [3:0] HOUR_TENS_MAX = 4'd2;
  localparam logic [3:0] HOUR_ONES_MAX = 4'd3;

  // True when a two-digit BCD field reads 00.
  function automatic logic bcd_is_zero(input logic [3:0] tens, input logic [3:0] ones);
    return (tens == 4'd0) && (ones == 4'd0);
  endfunction

endpackage

// File: rtl/clock_alarm_if.sv
// Time-of-day bus from the BCD time-keeping core to its consumers.
// The core drives (master); the alarm controller listens (slave).
interface clock_alarm_if;
  logic       tick_1hz;
  logic [3:0] hour_tens;
  logic [3:0] hour_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;

  modport master (
    output tick_1hz, hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones
  );

  modport slave (
    input tick_1hz, hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones
  );
endinterface

// File: rtl/clock_alarm_bcd_wrap_inc.sv
// Two-digit BCD incrementer that rolls over to 00 after a chosen value
// (23 for hours, 59 for minutes). No carry out: the caller decides what wraps.
module bcd_wrap_inc
  import clock_alarm_pkg::*;
#(
  parameter logic [3:0] WRAP_TENS = MIN_TENS_MAX,
  parameter logic [3:0] WRAP_ONES = BCD_ONES_MAX
) (
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  output logic [3:0] tens_out,
  output logic [3:0] ones_out
);

  // Next BCD value: wrap to 00 at the limit, otherwise ripple ones into tens.
  always_comb begin
    tens_out = tens_in;
    ones_out = ones_in;
    if ((tens_in == WRAP_TENS) && (ones_in == WRAP_ONES)) begin
      tens_out = 4'd0;
      ones_out = 4'd0;
    end else if (ones_in >= BCD_ONES_MAX) begin
      tens_out = tens_in + 4'd1;
      ones_out = 4'd0;
    end else begin
      ones_out = ones_in + 4'd1;
    end
  end

endmodule

// File: rtl/clock_alarm_ctrl.sv
// Alarm controller: holds an HH:MM alarm time, detects the HH:MM:00 match on
// the time bus and sequences ring / snooze / dismiss with a pulsed buzzer.
// Optional hourly chime is built only when CLOCK_ALARM_CHIME_EN is defined;
// otherwise the chime output is tied low.
module clock_alarm_ctrl
  import clock_alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int CNT_W      = 10
) (
  input  logic                clk,
  input  logic                rst,
  clock_alarm_if.slave        time_bus,
  input  logic                armed,
  input  logic                alm_inc_hour,
  input  logic                alm_inc_min,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [3:0]          alm_hour_tens,
  output logic [3:0]          alm_hour_ones,
  output logic [3:0]          alm_min_tens,
  output logic [3:0]          alm_min_ones,
  output logic [1:0]          state,
  output logic                ringing,
  output logic                buzzer,
  output logic [1:0]          snooze_left,
  output logic                chime
);

  localparam logic [1:0]       SNOOZE_RELOAD = 2'(MAX_SNOOZE);
  localparam logic [CNT_W-1:0] RING_LAST     = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST   = CNT_W'(SNOOZE_SEC - 1);

  logic             tick_d_q;
  logic [3:0]       alm_ht_q, alm_ho_q, alm_mt_q, alm_mo_q;
  logic [3:0]       alm_ht_d, alm_ho_d, alm_mt_d, alm_mo_d;
  logic [3:0]       hour_inc_t, hour_inc_o, min_inc_t, min_inc_o;
  alarm_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buzzer_q, buzzer_d;
  logic             ringing_q, ringing_d;
  logic [1:0]       snooze_left_q, snooze_left_d;
  logic             time_match;
  logic             sec_zero;

  bcd_wrap_inc #(.WRAP_TENS(HOUR_TENS_MAX), .WRAP_ONES(HOUR_ONES_MAX)) u_hour_inc (
    .tens_in  (alm_ht_q),
    .ones_in  (alm_ho_q),
    .tens_out (hour_inc_t),
    .ones_out (hour_inc_o)
  );

  bcd_wrap_inc #(.WRAP_TENS(MIN_TENS_MAX), .WRAP_ONES(BCD_ONES_MAX)) u_min_inc (
    .tens_in  (alm_mt_q),
    .ones_in  (alm_mo_q),
    .tens_out (min_inc_t),
    .ones_out (min_inc_o)
  );

  // Time digits are read the cycle after the tick, once the core has updated them.
  assign sec_zero   = bcd_is_zero(time_bus.sec_tens, time_bus.sec_ones);
  assign time_match = armed && tick_d_q && sec_zero &&
                      (time_bus.hour_tens == alm_ht_q) && (time_bus.hour_ones == alm_ho_q) &&
                      (time_bus.min_tens  == alm_mt_q) && (time_bus.min_ones  == alm_mo_q);

  // Alarm edits apply independently; minute rollover never touches the hour.
  always_comb begin
    alm_ht_d = alm_ht_q;
    alm_ho_d = alm_ho_q;
    alm_mt_d = alm_mt_q;
    alm_mo_d = alm_mo_q;
    if (alm_inc_hour) begin
      alm_ht_d = hour_inc_t;
      alm_ho_d = hour_inc_o;
    end
    if (alm_inc_min) begin
      alm_mt_d = min_inc_t;
      alm_mo_d = min_inc_o;
    end
  end

  // Next-state and output decode; disarming beats dismiss beats snooze beats timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    buzzer_d      = buzzer_q;
    snooze_left_d = snooze_left_q;
    if (!armed) begin
      state_d       = ST_IDLE;
      cnt_d         = '0;
      buzzer_d      = 1'b0;
      snooze_left_d = SNOOZE_RELOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (time_match) begin
            state_d  = ST_RING;
            cnt_d    = '0;
            buzzer_d = 1'b1;
          end
        end
        ST_RING: begin
          if (dismiss) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            buzzer_d      = 1'b0;
            snooze_left_d = SNOOZE_RELOAD;
          end else if (snooze && (snooze_left_q != 2'd0)) begin
            state_d       = ST_SNOOZE;
            cnt_d         = '0;
            buzzer_d      = 1'b0;
            snooze_left_d = snooze_left_q - 2'd1;
          end else if (tick_d_q) begin
            if (cnt_q == RING_LAST) begin
              state_d       = ST_IDLE;
              cnt_d         = '0;
              buzzer_d      = 1'b0;
              snooze_left_d = SNOOZE_RELOAD;
            end else begin
              cnt_d    = cnt_q + 1'b1;
              buzzer_d = ~buzzer_q;
            end
          end
        end
        ST_SNOOZE: begin
          if (dismiss) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            buzzer_d      = 1'b0;
            snooze_left_d = SNOOZE_RELOAD;
          end else if (tick_d_q) begin
            if (cnt_q == SNOOZE_LAST) begin
              state_d  = ST_RING;
              cnt_d    = '0;
              buzzer_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          buzzer_d      = 1'b0;
          snooze_left_d = SNOOZE_RELOAD;
        end
      endcase
    end
    ringing_d = (state_d == ST_RING);
  end

  // Single register bank for the sequencer, alarm time and delayed tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_d_q      <= 1'b0;
      alm_ht_q      <= 4'd0;
      alm_ho_q      <= 4'd0;
      alm_mt_q      <= 4'd0;
      alm_mo_q      <= 4'd0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      buzzer_q      <= 1'b0;
      ringing_q     <= 1'b0;
      snooze_left_q <= SNOOZE_RELOAD;
    end else begin
      tick_d_q      <= time_bus.tick_1hz;
      alm_ht_q      <= alm_ht_d;
      alm_ho_q      <= alm_ho_d;
      alm_mt_q      <= alm_mt_d;
      alm_mo_q      <= alm_mo_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      buzzer_q      <= buzzer_d;
      ringing_q     <= ringing_d;
      snooze_left_q <= snooze_left_d;
    end
  end

`ifdef CLOCK_ALARM_CHIME_EN
  logic chime_q, chime_d;

  // One-cycle chime at the top of each hour while idle, unless the alarm fires then.
  always_comb begin
    chime_d = armed && (state_q == ST_IDLE) && tick_d_q && sec_zero &&
              bcd_is_zero(time_bus.min_tens, time_bus.min_ones) && !time_match;
  end

  // Chime register.
  always_ff @(posedge clk) begin
    if (rst) chime_q <= 1'b0;
    else     chime_q <= chime_d;
  end

  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif

  assign alm_hour_tens = alm_ht_q;
  assign alm_hour_ones = alm_ho_q;
  assign alm_min_tens  = alm_mt_q;
  assign alm_min_ones  = alm_mo_q;
  assign state         = state_q;
  assign ringing       = ringing_q;
  assign buzzer        = buzzer_q;
  assign snooze_left   = snooze_left_q;

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Directed testbench for clock_alarm_ctrl. Chime expectations follow
// CLOCK_ALARM_CHIME_EN so the bench matches either build.
module tb_clock_alarm_ctrl;

  logic clk;
  logic rst;
  logic armed;
  logic alm_inc_hour;
  logic alm_inc_min;
  logic snooze;
  logic dismiss;
  logic [3:0] alm_hour_tens, alm_hour_ones, alm_min_tens, alm_min_ones;
  logic [1:0] state;
  logic ringing;
  logic buzzer;
  logic [1:0] snooze_left;
  logic chime;

  int checks = 0;
  int errors = 0;

`ifdef CLOCK_ALARM_CHIME_EN
  localparam logic CHIME_EXP = 1'b1;
`else
  localparam logic CHIME_EXP = 1'b0;
`endif

  clock_alarm_if tb_bus ();

  clock_alarm_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .time_bus      (tb_bus),
    .armed         (armed),
    .alm_inc_hour  (alm_inc_hour),
    .alm_inc_min   (alm_inc_min),
    .snooze        (snooze),
    .dismiss       (dismiss),
    .alm_hour_tens (alm_hour_tens),
    .alm_hour_ones (alm_hour_ones),
    .alm_min_tens  (alm_min_tens),
    .alm_min_ones  (alm_min_ones),
    .state         (state),
    .ringing       (ringing),
    .buzzer        (buzzer),
    .snooze_left   (snooze_left),
    .chime         (chime)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setTime(input int h, input int m, input int s);
    tb_bus.hour_tens = 4'(h / 10);
    tb_bus.hour_ones = 4'(h % 10);
    tb_bus.min_tens  = 4'(m / 10);
    tb_bus.min_ones  = 4'(m % 10);
    tb_bus.sec_tens  = 4'(s / 10);
    tb_bus.sec_ones  = 4'(s % 10);
  endtask

  // One-cycle pulse on the control inputs; returns on the negedge after it was sampled.
  task automatic applyStimulus(input logic inc_h, input logic inc_m, input logic snz, input logic dis);
    @(negedge clk);
    alm_inc_hour = inc_h;
    alm_inc_min  = inc_m;
    snooze       = snz;
    dismiss      = dis;
    @(negedge clk);
    alm_inc_hour = 1'b0;
    alm_inc_min  = 1'b0;
    snooze       = 1'b0;
    dismiss      = 1'b0;
  endtask

  // Tick pulse, time updates on its edge, then wait until the delayed tick has acted.
  task automatic tickTo(input int h, input int m, input int s);
    @(negedge clk);
    tb_bus.tick_1hz = 1'b1;
    @(negedge clk);
    tb_bus.tick_1hz = 1'b0;
    setTime(h, m, s);
    @(negedge clk);
  endtask

  task automatic checkAlarm(input string tag, input int h, input int m);
    checkOutput({tag, "_ht"}, alm_hour_tens, 32'(h / 10));
    checkOutput({tag, "_ho"}, alm_hour_ones, 32'(h % 10));
    checkOutput({tag, "_mt"}, alm_min_tens,  32'(m / 10));
    checkOutput({tag, "_mo"}, alm_min_ones,  32'(m % 10));
  endtask

  initial begin
    rst = 1'b1;
    armed = 1'b0;
    alm_inc_hour = 1'b0;
    alm_inc_min = 1'b0;
    snooze = 1'b0;
    dismiss = 1'b0;
    tb_bus.tick_1hz = 1'b0;
    setTime(0, 0, 5);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    checkAlarm("rst_alarm", 0, 0);
    checkOutput("rst_state", state, 32'd0);
    checkOutput("rst_ringing", ringing, 32'd0);
    checkOutput("rst_buzzer", buzzer, 32'd0);
    checkOutput("rst_snooze_left", snooze_left, 32'd3);
    checkOutput("rst_chime", chime, 32'd0);

    // Program alarm 07:30 and arm
    repeat (7) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkAlarm("set_0730", 7, 30);
    armed = 1'b1;

    tickTo(7, 29, 59);
    checkOutput("pre_match_state", state, 32'd0);

    // Match: ringing appears one edge after the delayed tick
    @(negedge clk);
    tb_bus.tick_1hz = 1'b1;
    @(negedge clk);
    tb_bus.tick_1hz = 1'b0;
    setTime(7, 30, 0);
    checkOutput("match_not_yet", ringing, 32'd0);
    @(negedge clk);
    checkOutput("match_ringing", ringing, 32'd1);
    checkOutput("match_buzzer", buzzer, 32'd1);
    checkOutput("match_state", state, 32'd1);

    // Ring with no input: buzzer toggles every tick, back to IDLE on tick 60
    for (int k = 1; k <= 60; k++) begin
      tickTo(7, 30, 1);
      checkOutput($sformatf("ring_state_%0d", k), state, (k < 60) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ring_buzzer_%0d", k), buzzer, (k < 60 && (k % 2) == 0) ? 32'd1 : 32'd0);
    end
    checkOutput("timeout_ringing", ringing, 32'd0);
    checkOutput("timeout_snooze_left", snooze_left, 32'd3);

    // Three snooze cycles then a fourth snooze is ignored
    tickTo(7, 30, 0);
    checkOutput("retrig_state", state, 32'd1);
    for (int s = 1; s <= 3; s++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("snz%0d_state", s), state, 32'd2);
      checkOutput($sformatf("snz%0d_left", s), snooze_left, 32'(3 - s));
      checkOutput($sformatf("snz%0d_buzzer", s), buzzer, 32'd0);
      repeat (299) tickTo(7, 30, 5);
      checkOutput($sformatf("snz%0d_still", s), state, 32'd2);
      tickTo(7, 30, 5);
      checkOutput($sformatf("snz%0d_rering", s), state, 32'd1);
      checkOutput($sformatf("snz%0d_rebuzz", s), buzzer, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("snz4_state", state, 32'd1);
    checkOutput("snz4_left", snooze_left, 32'd0);

    // Snooze and dismiss together: dismiss wins
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("snzdis_state", state, 32'd0);
    checkOutput("snzdis_left", snooze_left, 32'd3);
    checkOutput("snzdis_ringing", ringing, 32'd0);

    // Match while ringing does not re-trigger
    tickTo(7, 30, 0);
    tickTo(7, 30, 1);
    tickTo(7, 30, 2);
    checkOutput("noretrig_pre", buzzer, 32'd1);
    tickTo(7, 30, 0);
    checkOutput("noretrig_buzzer", buzzer, 32'd0);
    checkOutput("noretrig_state", state, 32'd1);

    // Disarm mid-snooze
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("disarm_pre_state", state, 32'd2);
    tickTo(7, 30, 5);
    tickTo(7, 30, 6);
    armed = 1'b0;
    @(negedge clk);
    checkOutput("disarm_state", state, 32'd0);
    checkOutput("disarm_left", snooze_left, 32'd3);
    armed = 1'b1;

    // Hourly chime
    tickTo(8, 0, 0);
    checkOutput("chime_top", chime, 32'(CHIME_EXP));
    @(negedge clk);
    checkOutput("chime_one_cycle", chime, 32'd0);
    tickTo(8, 1, 0);
    checkOutput("chime_not_top", chime, 32'd0);

    // Reset mid-ring clears everything including the alarm time
    tickTo(7, 30, 0);
    checkOutput("rst_ring_pre", state, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_ring_state", state, 32'd0);
    checkOutput("rst_ring_ringing", ringing, 32'd0);
    checkOutput("rst_ring_buzzer", buzzer, 32'd0);
    checkAlarm("rst_ring_alarm", 0, 0);

    // Alarm edit boundaries
    repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkAlarm("hour_09", 9, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkAlarm("hour_10", 10, 0);
    repeat (13) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkAlarm("hour_23", 23, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkAlarm("hour_wrap", 0, 0);
    repeat (59) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkAlarm("min_59", 0, 59);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkAlarm("min_wrap", 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkAlarm("both_inc", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
